qpsk_burst_sequencer: RTL and testbench
=======================================

// Module: qpsk_burst_sequencer
// PURPOSE
//  Burst-level controller for the QPSK transmit path. It owns the DDS carrier generator:
//  drives its FCW and active-low reset, and sequences PREAMBLE -> DATA -> TAIL symbol periods.
//  It pulls 2-bit symbols from an upstream valid/ready source and presents I/Q sign bits to the mixer stage.
// PARAMETERS
//  FCW_W        32  carrier frequency control word width (matches DDS)
//  PREAMBLE_LEN 32  preamble length in symbols; pattern 00,11,00,11,...; must be >=1
//  TAIL_LEN     4   guard symbols after data; tx_en low, carrier running; must be >=1
//  CNT_W        16  width of the sample, symbol and burst counters
// PORTS
//  clk          in   1      clock
//  reset        in   1      asynchronous, active-low reset
//  start        in   1      one-cycle request to begin a burst; ignored while busy
//  cfg_fcw      in   FCW_W  carrier FCW, latched on accepted start
//  cfg_sps      in   CNT_W  samples per symbol, latched on start; values <2 are clamped to 2
//  cfg_len      in   CNT_W  number of DATA symbols, latched on start; 0 is legal
//  s_sym_data   in   2      symbol: bit1 -> I, bit0 -> Q (0 = +1, 1 = -1)
//  s_sym_valid  in   1      upstream symbol valid
//  s_sym_ready  out  1      asserted only on DATA symbol-boundary cycles
//  dds_fcw      out  FCW_W  FCW to DDS; holds the latched value, reset 0
//  dds_rst_n    out  1      DDS reset; 0 in IDLE (phase held at 0), 1 while busy
//  sym_i        out  1      current I sign; reset 0
//  sym_q        out  1      current Q sign; reset 0
//  sym_strobe   out  1      1-cycle pulse on the first sample of every symbol (all states); reset 0
//  tx_en        out  1      1 in PREAMBLE and DATA, 0 otherwise; reset 0
//  busy         out  1      1 from the cycle after start through the last TAIL sample; reset 0
//  done         out  1      1-cycle pulse on the cycle after the last TAIL sample; reset 0
//  underrun     out  1      sticky; set on a DATA boundary with s_sym_valid=0; cleared on start
// BEHAVIOUR
//  - States: IDLE, PREAMBLE, DATA, TAIL. Counters: samp_cnt (0..sps-1), sym_cnt.
//    A boundary is samp_cnt==0.
//  - IDLE & start=1 at cycle T: latch cfg_* and clear underrun.
//    At T+1: state=PREAMBLE, busy=1, dds_rst_n=1, sym_strobe=1, preamble symbol 0 is on sym_i/q.
//  - Symbol k of a state occupies samples k*sps .. k*sps+sps-1.
//    The last sample of the final symbol transitions state on the next clock.
//  - PREAMBLE: symbol k is 00 for even k, 11 for odd k.
//    After PREAMBLE_LEN symbols: DATA if len>0, else TAIL.
//  - DATA: s_sym_ready=1 exactly on boundary cycles. On valid&ready, s_sym_data drives sym_i/q
//    in that same cycle (registered output: visible the cycle the strobe is visible).
//  - DATA underrun: if valid=0 on a boundary, transmit 00, set underrun, and still count the symbol.
//    The burst length never stretches.
//  - After cfg_len DATA symbols: TAIL. sym_i/q=0 and tx_en=0; the carrier keeps running.
//    After TAIL_LEN symbols: IDLE, with busy=0, dds_rst_n=0 and done=1 for one cycle.
//  - dds_fcw keeps the latched value after the burst ends; it changes only on the next accepted start.
//  - start while busy: ignored. It has no effect on the latched config or on underrun.
//  - Counter wrap: sym_cnt compares with ==, not >=. cfg_len=16'hFFFF is legal.
//  - Reset asserted mid-burst: all outputs go to reset values at once (dds_rst_n=0, tx_en=0);
//    state goes to IDLE and no done pulse is generated.
// CONFIGURATION
//  DIFF_ENC_EN defined:
//  - DATA symbols are differentially encoded: out = (prev + in) mod 4, where prev is the last
//    transmitted symbol as a 2-bit value {i,q}.
//  - prev is loaded with the final preamble symbol at PREAMBLE exit and updates on every DATA
//    symbol, including underrun symbols, which use in=00.
//  DIFF_ENC_EN undefined: DATA symbols pass straight through; no prev register is built.
// STRUCTURE
//  - Shared package qpsk_pkg:
//    - state enum qpsk_seq_state_t {IDLE, PREAMBLE, DATA, TAIL};
//    - constants PREAMBLE_SYM_EVEN=2'b00, PREAMBLE_SYM_ODD=2'b11, SPS_MIN=2.
//  - One sub-module: qpsk_symbol_timer. It holds the samp_cnt/sym_cnt pair with load, boundary
//    and last-symbol outputs. The FSM and the mapping stay in the top level.
// TESTING
//  1. sps=4, len=3, data 01,10,11, valid always 1:
//     - sym_strobe every 4 cycles; preamble 00/11 alternating x32;
//     - data I/Q = (0,1),(1,0),(1,1); 4 TAIL symbols;
//     - done 1 cycle after the 156th sample; dds_rst_n low again.
//  2. len=0: PREAMBLE goes straight to TAIL; s_sym_ready never asserts; underrun stays 0.
//  3. len=4 with valid low on symbol 2 only:
//     - that symbol transmits 00 and underrun=1 stays set after done;
//     - the next start clears it.
//  4. cfg_sps=0 and cfg_sps=1: symbol period is 2 cycles; cfg_sps=3 gives 3 cycles.
//  5. start re-pulsed during DATA with a different cfg_fcw: dds_fcw, the burst length and the
//     timing are all unchanged.
//  6. Reset during DATA symbol 1:
//     - all outputs at reset values in the same cycle; no done;
//     - a new start then runs a full burst.
//     With DIFF_ENC_EN: data 01,01 after preamble end 11 -> transmitted 00,01.

Source files
------------

// File: rtl/qpsk_pkg.sv
// Shared types and constants for the QPSK burst sequencer.
package qpsk_pkg;

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, TAIL} qpsk_seq_state_t;

  localparam logic [1:0] PREAMBLE_SYM_EVEN = 2'b00;
  localparam logic [1:0] PREAMBLE_SYM_ODD  = 2'b11;
  localparam int         SPS_MIN           = 2;

endpackage

// File: rtl/qpsk_symbol_timer.sv
// Sample/symbol counter pair: boundary on sample 0, last on final sample of symbol sym_last_idx.
// Zero-latency combinational flags; load clears both counters on the next clock.
module qpsk_symbol_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] sps,
  input  logic [CNT_W-1:0] sym_last_idx,
  output logic             boundary,
  output logic             sym_odd,
  output logic             last
);

  logic [CNT_W-1:0] samp_q, samp_d;
  logic [CNT_W-1:0] sym_q, sym_d;
  logic             samp_last;

  assign samp_last = (samp_q == sps - CNT_W'(1));
  assign boundary  = (samp_q == '0);
  assign sym_odd   = sym_q[0];
  // Equality, not >=, so a full-range symbol count still terminates exactly.
  assign last      = samp_last && (sym_q == sym_last_idx);

  always_comb begin
    samp_d = samp_q + CNT_W'(1);
    sym_d  = sym_q;
    if (load) begin
      samp_d = '0;
      sym_d  = '0;
    end else if (samp_last) begin
      samp_d = '0;
      sym_d  = sym_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      samp_q <= '0;
      sym_q  <= '0;
    end else begin
      samp_q <= samp_d;
      sym_q  <= sym_d;
    end
  end

endmodule

// File: rtl/qpsk_burst_sequencer.sv
// QPSK burst controller: PREAMBLE -> DATA -> TAIL, drives DDS FCW/reset and I/Q signs.
// Optional DIFF_ENC_EN builds a differential encoder on DATA symbols.
module qpsk_burst_sequencer
  import qpsk_pkg::*;
#(
  parameter int FCW_W        = 32,
  parameter int PREAMBLE_LEN = 32,
  parameter int TAIL_LEN     = 4,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [FCW_W-1:0] cfg_fcw,
  input  logic [CNT_W-1:0] cfg_sps,
  input  logic [CNT_W-1:0] cfg_len,
  input  logic [1:0]       s_sym_data,
  input  logic             s_sym_valid,
  output logic             s_sym_ready,
  output logic [FCW_W-1:0] dds_fcw,
  output logic             dds_rst_n,
  output logic             sym_i,
  output logic             sym_q,
  output logic             sym_strobe,
  output logic             tx_en,
  output logic             busy,
  output logic             done,
  output logic             underrun
);

  qpsk_seq_state_t  state_q, state_d;
  logic [FCW_W-1:0] fcw_q, fcw_d;
  logic [CNT_W-1:0] sps_q, sps_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             underrun_q, underrun_d;
  logic             done_q, done_d;
  logic [1:0]       hold_q, hold_d;
  logic [1:0]       sym_raw, data_sym, cur_sym;
  logic [CNT_W-1:0] sym_last_idx;
  logic             boundary, sym_odd, sym_last, tmr_load, data_bnd;

  qpsk_symbol_timer #(.CNT_W(CNT_W)) u_timer (
    .clk          (clk),
    .reset        (reset),
    .load         (tmr_load),
    .sps          (sps_q),
    .sym_last_idx (sym_last_idx),
    .boundary     (boundary),
    .sym_odd      (sym_odd),
    .last         (sym_last)
  );

  assign data_bnd = (state_q == DATA) && boundary;
  // A missing symbol still occupies its slot and is sent as 00.
  assign sym_raw  = s_sym_valid ? s_sym_data : 2'b00;

`ifdef DIFF_ENC_EN
  localparam logic [1:0] PRE_LAST = ((PREAMBLE_LEN - 1) % 2 != 0) ? PREAMBLE_SYM_ODD : PREAMBLE_SYM_EVEN;
  logic [1:0] prev_q, prev_d;

  assign data_sym = prev_q + sym_raw;

  always_comb begin
    prev_d = prev_q;
    if (state_q == PREAMBLE && sym_last) prev_d = PRE_LAST;
    else if (data_bnd)                   prev_d = data_sym;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) prev_q <= 2'b00;
    else        prev_q <= prev_d;
  end
`else
  assign data_sym = sym_raw;
`endif

  always_comb begin
    state_d      = state_q;
    fcw_d        = fcw_q;
    sps_d        = sps_q;
    len_d        = len_q;
    underrun_d   = underrun_q;
    done_d       = 1'b0;
    hold_d       = hold_q;
    sym_last_idx = '0;
    tmr_load     = sym_last;
    cur_sym      = 2'b00;
    case (state_q)
      IDLE: begin
        tmr_load = 1'b1;
        if (start) begin
          state_d    = PREAMBLE;
          fcw_d      = cfg_fcw;
          sps_d      = (cfg_sps < CNT_W'(SPS_MIN)) ? CNT_W'(SPS_MIN) : cfg_sps;
          len_d      = cfg_len;
          underrun_d = 1'b0;
        end
      end
      PREAMBLE: begin
        sym_last_idx = CNT_W'(PREAMBLE_LEN - 1);
        cur_sym      = sym_odd ? PREAMBLE_SYM_ODD : PREAMBLE_SYM_EVEN;
        if (sym_last) state_d = (len_q == '0) ? TAIL : DATA;
      end
      DATA: begin
        sym_last_idx = len_q - CNT_W'(1);
        // The accepted symbol appears on the same cycle as its strobe, then is held.
        cur_sym      = boundary ? data_sym : hold_q;
        if (boundary) begin
          hold_d = data_sym;
          if (!s_sym_valid) underrun_d = 1'b1;
        end
        if (sym_last) state_d = TAIL;
      end
      TAIL: begin
        sym_last_idx = CNT_W'(TAIL_LEN - 1);
        if (sym_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      fcw_q      <= '0;
      sps_q      <= CNT_W'(SPS_MIN);
      len_q      <= '0;
      underrun_q <= 1'b0;
      done_q     <= 1'b0;
      hold_q     <= 2'b00;
    end else begin
      state_q    <= state_d;
      fcw_q      <= fcw_d;
      sps_q      <= sps_d;
      len_q      <= len_d;
      underrun_q <= underrun_d;
      done_q     <= done_d;
      hold_q     <= hold_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign dds_rst_n   = busy;
  assign tx_en       = (state_q == PREAMBLE) || (state_q == DATA);
  assign sym_strobe  = busy && boundary;
  assign s_sym_ready = data_bnd;
  assign sym_i       = cur_sym[1];
  assign sym_q       = cur_sym[0];
  assign dds_fcw     = fcw_q;
  assign done        = done_q;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_qpsk_burst_sequencer.sv
// Self-checking bench: per-cycle comparison against a symbol-timeline reference model.
module tb_qpsk_burst_sequencer;

  localparam int FCW_W = 32;
  localparam int P     = 32;
  localparam int TL    = 4;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [FCW_W-1:0] cfg_fcw = '0;
  logic [CNT_W-1:0] cfg_sps = '0;
  logic [CNT_W-1:0] cfg_len = '0;
  logic [1:0]       s_sym_data = 2'b00;
  logic             s_sym_valid = 1'b0;
  logic             s_sym_ready;
  logic [FCW_W-1:0] dds_fcw;
  logic             dds_rst_n, sym_i, sym_q, sym_strobe, tx_en, busy, done, underrun;

  qpsk_burst_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .cfg_fcw     (cfg_fcw),
    .cfg_sps     (cfg_sps),
    .cfg_len     (cfg_len),
    .s_sym_data  (s_sym_data),
    .s_sym_valid (s_sym_valid),
    .s_sym_ready (s_sym_ready),
    .dds_fcw     (dds_fcw),
    .dds_rst_n   (dds_rst_n),
    .sym_i       (sym_i),
    .sym_q       (sym_q),
    .sym_strobe  (sym_strobe),
    .tx_en       (tx_en),
    .busy        (busy),
    .done        (done),
    .underrun    (underrun)
  );

  always #5 clk = ~clk;

  int         n_assert = 0;
  int         n_fail   = 0;
  logic [1:0] tx_data [0:255];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " fcw"},      64'(dds_fcw), 64'd0);
    chk({tag, " rst_n"},    64'(dds_rst_n), 64'd0);
    chk({tag, " iq"},       64'({sym_i, sym_q}), 64'd0);
    chk({tag, " strobe"},   64'(sym_strobe), 64'd0);
    chk({tag, " tx_en"},    64'(tx_en), 64'd0);
    chk({tag, " busy"},     64'(busy), 64'd0);
    chk({tag, " done"},     64'(done), 64'd0);
    chk({tag, " underrun"}, 64'(underrun), 64'd0);
    chk({tag, " ready"},    64'(s_sym_ready), 64'd0);
  endtask

  // Expected waveform is derived from the symbol timeline: cycle c is sample c%sps of symbol c/sps.
  task automatic burst(input string name, input int sps_cfg, input int len, input logic [31:0] fcw,
                       input int drop, input int restart_at, input int rst_at);
    int         sps, total, s, k, j;
    logic [1:0] exp_sym [0:255];
    logic [1:0] prev, d, e_sym;
    logic       ur_exp, in_data;
    string      t;
    sps   = (sps_cfg < 2) ? 2 : sps_cfg;
    total = (P + len + TL) * sps;
    prev  = ((P - 1) % 2 != 0) ? 2'b11 : 2'b00;
    for (int i = 0; i < len; i++) begin
      d = (i == drop) ? 2'b00 : tx_data[i];
`ifdef DIFF_ENC_EN
      prev       = prev + d;
      exp_sym[i] = prev;
`else
      exp_sym[i] = d;
`endif
    end

    @(negedge clk);
    cfg_fcw = fcw;
    cfg_sps = CNT_W'(sps_cfg);
    cfg_len = CNT_W'(len);
    start   = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    ur_exp = 1'b0;

    for (int c = 0; c <= total + 1; c++) begin
      s = c / sps;
      k = c % sps;
      j = s - P;
      in_data = (c < total) && (s >= P) && (s < P + len);
      if (in_data) begin
        s_sym_valid = (j != drop);
        s_sym_data  = tx_data[j];
      end else begin
        s_sym_valid = 1'b1;
        s_sym_data  = 2'($urandom);
      end
      if (c == restart_at) begin
        start   = 1'b1;
        cfg_fcw = ~fcw;
        cfg_len = CNT_W'(len + 5);
        cfg_sps = CNT_W'(sps + 1);
      end
      if (c == rst_at) begin
        #1 reset = 1'b0;
        #1 chk_reset_vals($sformatf("%s reset_mid c=%0d", name, c));
        for (int r = 0; r < 3; r++) begin
          @(negedge clk);
          chk($sformatf("%s no_done_in_reset r=%0d", name, r), 64'(done), 64'd0);
        end
        reset = 1'b1;
        start = 1'b0;
        return;
      end

      @(negedge clk);
      t = $sformatf("%s c=%0d", name, c);
      if (c < total) begin
        e_sym = (s < P) ? ((s % 2 != 0) ? 2'b11 : 2'b00) : (in_data ? exp_sym[j] : 2'b00);
        chk({t, " iq"},     64'({sym_i, sym_q}), 64'(e_sym));
        chk({t, " strobe"}, 64'(sym_strobe), 64'(k == 0));
        chk({t, " tx_en"},  64'(tx_en), 64'(s < P + len));
        chk({t, " ready"},  64'(s_sym_ready), 64'(in_data && k == 0));
        chk({t, " busy"},   64'(busy), 64'd1);
        chk({t, " rst_n"},  64'(dds_rst_n), 64'd1);
        chk({t, " done"},   64'(done), 64'd0);
      end else begin
        chk({t, " iq"},     64'({sym_i, sym_q}), 64'd0);
        chk({t, " strobe"}, 64'(sym_strobe), 64'd0);
        chk({t, " tx_en"},  64'(tx_en), 64'd0);
        chk({t, " ready"},  64'(s_sym_ready), 64'd0);
        chk({t, " busy"},   64'(busy), 64'd0);
        chk({t, " rst_n"},  64'(dds_rst_n), 64'd0);
        chk({t, " done"},   64'(done), 64'(c == total));
      end
      chk({t, " fcw"},      64'(dds_fcw), 64'(fcw));
      chk({t, " underrun"}, 64'(underrun), 64'(ur_exp));

      @(posedge clk);
      #1 start = 1'b0;
      if (in_data && k == 0 && j == drop) ur_exp = 1'b1;
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 chk_reset_vals("reset_state");
    @(negedge clk);
    reset = 1'b1;

    tx_data[0] = 2'b01; tx_data[1] = 2'b10; tx_data[2] = 2'b11;
    burst("t1_basic", 4, 3, 32'h1234_5678, -1, -1, -1);

    burst("t2_len0", 3, 0, 32'hCAFE_0001, -1, -1, -1);

    for (int i = 0; i < 8; i++) tx_data[i] = 2'($urandom);
    burst("t3_underrun", 4, 4, 32'h0BAD_F00D, 2, -1, -1);

    for (int i = 0; i < 8; i++) tx_data[i] = 2'($urandom);
    burst("t4_sps0", 0, 2, 32'h0000_0010, -1, -1, -1);
    burst("t4_sps1", 1, 2, 32'h0000_0011, -1, -1, -1);
    burst("t4_sps3", 3, 2, 32'h0000_0013, -1, -1, -1);

    burst("t5_restart", 4, 3, 32'h5555_AAAA, -1, (P + 1) * 4 + 1, -1);

    burst("t6_reset", 4, 3, 32'h7777_0000, -1, -1, (P + 1) * 4 + 1);
    tx_data[0] = 2'b01; tx_data[1] = 2'b01;
    burst("t6_after", 4, 2, 32'h7777_0001, -1, -1, -1);

    for (int n = 0; n < 4; n++) begin
      int rl;
      rl = $urandom_range(0, 6);
      for (int i = 0; i < 8; i++) tx_data[i] = 2'($urandom);
      burst($sformatf("rand%0d", n), $urandom_range(2, 5), rl, $urandom,
            (rl > 0) ? $urandom_range(0, rl) : -1, -1, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
